// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage-bus encodings and controller state type for the union-find decoder sequencer.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SPREAD_CLUSTER      = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW_BOUNDARY       = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SYNC_IS_ODD_CLUSTER = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SPREAD,
    SYNC,
    EVAL,
    GROW,
    DONE
  } ctrl_state_t;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_stage_controller.sv
// Sequences the planar-code union-find decoder: accepts a syndrome frame, then cycles the
// stage bus through spread/sync/evaluate/grow until no odd cluster remains or the
// iteration budget is spent, and finally presents a result handshake.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int CODE_DISTANCE  = 5,
  parameter int SPREAD_CYCLES  = 2 * CODE_DISTANCE,
  parameter int SYNC_CYCLES    = 2,
  parameter int MAX_ITERATIONS = CODE_DISTANCE,
  localparam int PU_COUNT      = CODE_DISTANCE * (CODE_DISTANCE - 1),
  localparam int ITER_W        = $clog2(MAX_ITERATIONS + 1),
  localparam int PHASE_W       = $clog2(maxOf(SPREAD_CYCLES, SYNC_CYCLES) + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   syndrome_valid,
  output logic                   syndrome_ready,
  input  logic [PU_COUNT-1:0]    syndromes_in,
  output logic [STAGE_WIDTH-1:0] stage,
  output logic [PU_COUNT-1:0]    is_error_syndromes,
  input  logic [PU_COUNT-1:0]    is_odd_clusters,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_W-1:0]      iteration_count,
  output logic                   timeout,
  output logic                   busy
);

  ctrl_state_t            r_state;
  ctrl_state_t            w_nextState;
  logic [STAGE_WIDTH-1:0] r_stage;
  logic [STAGE_WIDTH-1:0] w_stageNext;
  logic [PHASE_W-1:0]     r_phase;
  logic [ITER_W-1:0]      r_iter;
  logic                   r_timeout;
  logic [PU_COUNT-1:0]    r_errSyn;
  logic                   w_accept;
  logic                   w_anyOdd;
  logic                   w_budgetSpent;

  assign w_accept      = (r_state == IDLE) && syndrome_valid;
  assign w_anyOdd      = |is_odd_clusters;
  assign w_budgetSpent = (r_iter == ITER_W'(MAX_ITERATIONS));

  // State register; reset drops straight back to IDLE with the stage bus idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_stage <= STAGE_IDLE;
    end else begin
      r_state <= w_nextState;
      r_stage <= w_stageNext;
    end
  end

  // Next-state selection; SPREAD and SYNC exit when the phase counter reaches zero.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (syndrome_valid) w_nextState = LOAD;
      LOAD:    w_nextState = SPREAD;
      SPREAD:  if (r_phase == '0) w_nextState = SYNC;
      SYNC:    if (r_phase == '0) w_nextState = EVAL;
      EVAL:    w_nextState = (!w_anyOdd || w_budgetSpent) ? DONE : GROW;
      GROW:    w_nextState = SPREAD;
      DONE:    if (result_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Stage bus value for the state being entered, so the bus changes together with the state.
  always_comb begin
    w_stageNext = STAGE_IDLE;
    case (w_nextState)
      LOAD:    w_stageNext = STAGE_MEASUREMENT_LOADING;
      SPREAD:  w_stageNext = STAGE_SPREAD_CLUSTER;
      SYNC:    w_stageNext = STAGE_SYNC_IS_ODD_CLUSTER;
      GROW:    w_stageNext = STAGE_GROW_BOUNDARY;
      default: w_stageNext = STAGE_IDLE;
    endcase
  end

  // Phase down-counter loaded on entry to SPREAD/SYNC with one less than the hold length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
    end else if ((w_nextState == SPREAD) && (r_state != SPREAD)) begin
      r_phase <= PHASE_W'(SPREAD_CYCLES - 1);
    end else if ((w_nextState == SYNC) && (r_state != SYNC)) begin
      r_phase <= PHASE_W'(SYNC_CYCLES - 1);
    end else if (r_phase != '0) begin
      r_phase <= r_phase - PHASE_W'(1);
    end
  end

  // Frame capture, grow-round count and timeout flag; the frame is only replaced on the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_errSyn  <= '0;
      r_iter    <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_errSyn  <= syndromes_in;
      r_iter    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == GROW) begin
      r_iter <= r_iter + ITER_W'(1);
    end else if ((r_state == EVAL) && w_anyOdd && w_budgetSpent) begin
      r_timeout <= 1'b1;
    end
  end

  assign stage              = r_stage;
  assign is_error_syndromes = r_errSyn;
  assign iteration_count    = r_iter;
  assign timeout            = r_timeout;
  assign syndrome_ready     = (r_state == IDLE);
  assign busy               = (r_state != IDLE);
  assign result_valid       = (r_state == DONE);

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Scoreboard bench for decoder_stage_controller with a stub decoder driving is_odd_clusters.
module tb_decoder_stage_controller;
  import decoder_stage_controller_pkg::*;

  localparam int PU   = 20;
  localparam int SPR  = 10;
  localparam int SYN  = 2;
  localparam int MAXI = 5;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   syndrome_valid = 1'b0;
  logic                   syndrome_ready;
  logic [PU-1:0]          syndromes_in = '0;
  logic [STAGE_WIDTH-1:0] stage;
  logic [PU-1:0]          is_error_syndromes;
  logic [PU-1:0]          is_odd_clusters;
  logic                   result_valid;
  logic                   result_ready = 1'b0;
  logic [2:0]             iteration_count;
  logic                   timeout;
  logic                   busy;

  decoder_stage_controller dut (
    .clk                (clk),
    .reset              (reset),
    .syndrome_valid     (syndrome_valid),
    .syndrome_ready     (syndrome_ready),
    .syndromes_in       (syndromes_in),
    .stage              (stage),
    .is_error_syndromes (is_error_syndromes),
    .is_odd_clusters    (is_odd_clusters),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .iteration_count    (iteration_count),
    .timeout            (timeout),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int iter;
    int tmo;
    int lat;
  } result_t;

  result_t                resQ[$];
  logic [STAGE_WIDTH-1:0] stageQ[$];
  int                     total = 0;
  int                     bad = 0;

  // Stub decoder: reports odd clusters until it has seen kRounds grow stages.
  int            kRounds = 0;
  int            growsSeen = 0;
  logic [PU-1:0] oddPat = 20'h1;
  assign is_odd_clusters = (growsSeen < kRounds) ? oddPat : '0;

  always @(negedge clk) begin
    if (stage == STAGE_MEASUREMENT_LOADING) growsSeen = 0;
    else if (stage == STAGE_GROW_BOUNDARY) growsSeen = growsSeen + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected behaviour of one frame whose stub stays odd for k evaluations.
  task automatic pushExpect(input int k);
    int rounds;
    result_t r;
    rounds = (k < MAXI) ? k : MAXI;
    stageQ.push_back(STAGE_MEASUREMENT_LOADING);
    for (int g = 0; g <= rounds; g++) begin
      if (g > 0) stageQ.push_back(STAGE_GROW_BOUNDARY);
      for (int i = 0; i < SPR; i++) stageQ.push_back(STAGE_SPREAD_CLUSTER);
      for (int i = 0; i < SYN; i++) stageQ.push_back(STAGE_SYNC_IS_ODD_CLUSTER);
      stageQ.push_back(STAGE_IDLE);
    end
    r.iter = rounds;
    r.tmo  = (k > MAXI) ? 1 : 0;
    r.lat  = 3 + SPR + SYN + rounds * (SPR + SYN + 2);
    resQ.push_back(r);
  endtask

  // Monitor and model of the handshake-level behaviour, sampled on the falling edge.
  bit            modelIdle = 1'b1;
  bit            accPending = 1'b0;
  bit            relPending = 1'b0;
  bit            resultSeen = 1'b0;
  logic [PU-1:0] modelFrame = '0;
  logic [PU-1:0] pendFrame = '0;
  int            cnt = -1;

  always @(negedge clk) begin
    if (!reset) begin
      stageQ.delete();
      resQ.delete();
      modelIdle  = 1'b1;
      accPending = 1'b0;
      relPending = 1'b0;
      resultSeen = 1'b0;
      modelFrame = '0;
      cnt        = -1;
    end else begin
      if (relPending) begin
        modelIdle  = 1'b1;
        relPending = 1'b0;
      end
      if (accPending) begin
        modelIdle  = 1'b0;
        modelFrame = pendFrame;
        accPending = 1'b0;
        resultSeen = 1'b0;
        cnt        = 0;
      end
      if (cnt >= 0) cnt++;
      checkOutput("syndromeReady", syndrome_ready, modelIdle);
      checkOutput("busy", busy, !modelIdle);
      checkOutput("frameHold", is_error_syndromes, modelFrame);
      if (modelIdle) begin
        checkOutput("idleResultValid", result_valid, 0);
        checkOutput("idleStage", stage, STAGE_IDLE);
      end else if (stageQ.size() > 0) begin
        checkOutput("stage", stage, stageQ.pop_front());
        checkOutput("earlyResultValid", result_valid, 0);
      end else if (resQ.size() == 0) begin
        checkOutput("resultQueue", resQ.size(), 1);
      end else begin
        checkOutput("resultValid", result_valid, 1);
        checkOutput("iterationCount", iteration_count, resQ[0].iter);
        checkOutput("timeout", timeout, resQ[0].tmo);
        checkOutput("doneStage", stage, STAGE_IDLE);
        if (!resultSeen) begin
          checkOutput("latency", cnt, resQ[0].lat);
          resultSeen = 1'b1;
        end
        if (result_ready) begin
          relPending = 1'b1;
          resQ.delete(0);
          cnt = -1;
        end
      end
      if (modelIdle && syndrome_valid) begin
        accPending = 1'b1;
        pendFrame  = syndromes_in;
      end
    end
  end

  task automatic waitAccept(input int k, input bit junk);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      if (syndrome_ready) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptWait: frame not taken within %0d cycles", n);
    end else begin
      pushExpect(k);
    end
    @(posedge clk);
    #1;
    syndrome_valid = junk;
    if (junk) syndromes_in = 20'hAAAAA;
  endtask

  task automatic offerFrame(input logic [PU-1:0] frame, input int k, input bit junk);
    @(posedge clk);
    #1;
    kRounds        = k;
    oddPat         = PU'($urandom) | 20'h1;
    syndromes_in   = frame;
    syndrome_valid = 1'b1;
    waitAccept(k, junk);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (result_valid) break;
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("[TB] FAIL doneWait: result_valid not seen within %0d cycles", n);
    end
  endtask

  task automatic releaseResult(input int hold);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    result_ready   = 1'b0;
    syndrome_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [PU-1:0] frame, input int k, input int hold, input bit junk);
    offerFrame(frame, k, junk);
    waitDone();
    releaseResult(hold);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #3;
    checkOutput("resetStage", stage, STAGE_IDLE);
    checkOutput("resetFrame", is_error_syndromes, 0);
    checkOutput("resetIter", iteration_count, 0);
    checkOutput("resetTimeout", timeout, 0);
    checkOutput("resetResultValid", result_valid, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetReady", syndrome_ready, 1);
    #19;
    reset = 1'b1;

    applyStimulus(20'h00000, 0, 0, 1'b0);
    applyStimulus(20'h00003, 3, 0, 1'b0);
    applyStimulus(20'h5A5A5, 100, 1, 1'b1);

    offerFrame(20'h12345, 2, 1'b0);
    waitDone();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    result_ready   = 1'b1;
    kRounds        = 1;
    syndromes_in   = 20'h0F0F0;
    syndrome_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    waitAccept(1, 1'b0);
    waitDone();
    releaseResult(0);

    offerFrame(20'h77777, 4, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midResetStage", stage, STAGE_IDLE);
    checkOutput("midResetFrame", is_error_syndromes, 0);
    checkOutput("midResetIter", iteration_count, 0);
    checkOutput("midResetTimeout", timeout, 0);
    checkOutput("midResetResultValid", result_valid, 0);
    checkOutput("midResetBusy", busy, 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(20'h00005, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(PU'($urandom), $urandom_range(0, 7), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    checkOutput("queuesDrained", stageQ.size() + resQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
